// File: rtl/serial_link_pkg.sv
// Shared constants and helpers for both ends of the 16-slot serial link.
package serial_link_pkg;

    localparam int SL_DATA_WIDTH = 15;
    localparam int SL_FRAME_LEN  = 16;

    localparam logic SL_FLAG_DATA = 1'b1;
    localparam logic SL_FLAG_IDLE = 1'b0;

    // Kind of frame currently on the wire; the encoding equals the flag bit.
    typedef enum logic {
        FRAME_IDLE = 1'b0,
        FRAME_DATA = 1'b1
    } frame_type_e;

    // Width of a slot counter that must count 0..last_slot inclusive.
    function automatic int sl_slot_width(input int last_slot);
        int w;
        w = $clog2(last_slot + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_slot_counter.sv
// Free-running 0..LAST wrap counter that defines slot alignment on the link.
// Never stalls; both link ends run one from the same reset release.
module serial_slot_counter
    import serial_link_pkg::*;
#(
    parameter int LAST = SL_DATA_WIDTH
) (
    input  logic clock,
    input  logic reset,
    output logic last_slot,
    output logic first_slot
);

    localparam int W = sl_slot_width(LAST);
    localparam logic [W-1:0] LAST_SLOT = W'(LAST);

    logic [W-1:0] slot_r;
    logic [W-1:0] slot_s;

    // Next slot: wrap to zero after the last slot, otherwise step by one.
    always_comb begin
        slot_s = slot_r;
        if (slot_r == LAST_SLOT) begin
            slot_s = '0;
        end else begin
            slot_s = slot_r + W'(1);
        end
    end

    // Slot register plus registered slot-0 decode so first_slot is glitch free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_r     <= '0;
            first_slot <= 1'b1;
        end else begin
            slot_r     <= slot_s;
            first_slot <= (slot_s == '0);
        end
    end

    assign last_slot = (slot_r == LAST_SLOT);

endmodule

// File: rtl/serial_frame_transmitter.sv
// Parallel-to-serial frame transmitter: one flag bit then DATA_WIDTH payload
// bits, MSB first, back to back. One word buffered in hold, one in the shifter.
module serial_frame_transmitter
    import serial_link_pkg::*;
#(
    parameter int DATA_WIDTH = SL_DATA_WIDTH
) (
    input  logic                  serial_clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  serial_data,
    output logic                  frame_start,
    output logic                  busy
);

    logic                  boundary_s;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [DATA_WIDTH-1:0] shreg_s;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] hold_s;
    logic                  hold_full_r;
    logic                  hold_full_s;
    frame_type_e           frame_valid_r;
    frame_type_e           frame_valid_s;
    logic                  serial_s;

    serial_slot_counter #(
        .LAST(DATA_WIDTH)
    ) u_slot_counter (
        .clock      (serial_clock),
        .reset      (reset),
        .last_slot  (boundary_s),
        .first_slot (frame_start)
    );

    // Next-state: shift out payload, load a new frame at the boundary, accept words.
    always_comb begin
        shreg_s       = shreg_r;
        hold_s        = hold_r;
        hold_full_s   = hold_full_r;
        frame_valid_s = frame_valid_r;
        serial_s      = serial_data;

        if (boundary_s) begin
            if (hold_full_r) begin
                serial_s      = SL_FLAG_DATA;
                shreg_s       = hold_r;
                frame_valid_s = FRAME_DATA;
                hold_full_s   = 1'b0;
            end else begin
                serial_s      = SL_FLAG_IDLE;
                shreg_s       = '0;
                frame_valid_s = FRAME_IDLE;
            end
        end else begin
            serial_s = shreg_r[DATA_WIDTH-1];
            shreg_s  = shreg_r << 1;
        end

        // Ready is the registered !hold_full, so an accept can never collide
        // with the boundary load emptying hold in the same cycle.
        if (data_valid && !hold_full_r) begin
            hold_s      = data_in;
            hold_full_s = 1'b1;
        end else begin
            hold_s = hold_s;
        end
    end

    // State and output registers; reset abandons any partial frame and buffered word.
    always_ff @(posedge serial_clock or posedge reset) begin
        if (reset) begin
            serial_data   <= 1'b0;
            shreg_r       <= '0;
            hold_r        <= '0;
            hold_full_r   <= 1'b0;
            frame_valid_r <= FRAME_IDLE;
            data_ready    <= 1'b1;
        end else begin
            serial_data   <= serial_s;
            shreg_r       <= shreg_s;
            hold_r        <= hold_s;
            hold_full_r   <= hold_full_s;
            frame_valid_r <= frame_valid_s;
            data_ready    <= !hold_full_s;
        end
    end

    assign busy = (frame_valid_r == FRAME_DATA);

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Self-checking bench for serial_frame_transmitter: frame-level reference
// model, per-cycle compare, loopback receiver and directed + random stimulus.
module tb_serial_frame_transmitter;
    import serial_link_pkg::*;

    localparam int DW   = SL_DATA_WIDTH;
    localparam int FL   = SL_FRAME_LEN;
    localparam int MAXF = 1024;

    logic          serial_clock = 1'b0;
    logic          reset        = 1'b1;
    logic [DW-1:0] data_in      = '0;
    logic          data_valid   = 1'b0;
    logic          data_ready;
    logic          serial_data;
    logic          frame_start;
    logic          busy;

    serial_frame_transmitter #(.DATA_WIDTH(DW)) dut (
        .serial_clock (serial_clock),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .serial_data  (serial_data),
        .frame_start  (frame_start),
        .busy         (busy)
    );

    always #5 serial_clock = ~serial_clock;

    int checks = 0;
    int passes = 0;
    bit run_cmp = 1'b0;

    // Reference model: edge count since release, frame contents by frame index,
    // and the words waiting for a frame.
    int            k;
    bit            fdata [MAXF];
    logic [DW-1:0] fword [MAXF];
    logic [DW-1:0] pend [$];
    int            mp, mf;
    bit            mrdy;

    // Loopback receiver log
    logic          rx_flag;
    logic [DW-1:0] rx_sh;
    logic [DW-1:0] rx_words [$];
    int            rx_edges [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, k, $time);
        end else begin
            passes++;
        end
    endtask

    // Model update at each edge: frame content chosen at the frame's last slot
    always @(posedge serial_clock or posedge reset) begin
        if (reset) begin
            k        = 0;
            pend.delete();
            fdata[0] = 1'b0;
            fword[0] = '0;
            rx_flag  = 1'b0;
            rx_sh    = '0;
        end else begin
            mp   = k % FL;
            mrdy = (pend.size() == 0);
            if (mp == 0) rx_flag = serial_data;
            else         rx_sh   = {rx_sh[DW-2:0], serial_data};
            if (mp == FL - 1 && rx_flag) begin
                rx_words.push_back(rx_sh);
                rx_edges.push_back(k);
            end
            if (mp == FL - 1) begin
                mf = k / FL + 1;
                if (mf < MAXF) begin
                    if (pend.size() > 0) begin
                        fdata[mf] = 1'b1;
                        fword[mf] = pend.pop_front();
                    end else begin
                        fdata[mf] = 1'b0;
                        fword[mf] = '0;
                    end
                end
            end
            if (data_valid && mrdy) pend.push_back(data_in);
            k++;
        end
    end

    // Compare DUT outputs with the model on every falling edge
    always @(negedge serial_clock) begin
        if (!reset && run_cmp) begin
            int f, p;
            logic exp_s;
            f = k / FL;
            p = k % FL;
            if (f < MAXF) begin
                if (p == 0)        exp_s = fdata[f];
                else if (fdata[f]) exp_s = fword[f][DW-p];
                else               exp_s = 1'b0;
                chk("serial_data", 32'(serial_data), 32'(exp_s));
                chk("frame_start", 32'(frame_start), 32'(p == 0));
                chk("busy",        32'(busy),        32'(fdata[f]));
                chk("data_ready",  32'(data_ready),  32'(pend.size() == 0));
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        data_valid = 1'b0;
        repeat (2) @(negedge serial_clock);
        #1 reset = 1'b0;
        run_cmp = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] w);
        int n = 0;
        data_in    = w;
        data_valid = 1'b1;
        while (!data_ready && n < 64) begin
            @(negedge serial_clock);
            n++;
        end
        if (!data_ready) chk("send_timeout", 32'(data_ready), 32'd1);
        @(negedge serial_clock);
        data_valid = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_words.size() < target && n < budget) begin
            @(negedge serial_clock);
            n++;
        end
        if (rx_words.size() < target) chk("rx_timeout", 32'(rx_words.size()), 32'(target));
    endtask

    initial begin
        int base;
        int n;

        // Idle link after reset
        do_reset();
        chk("reset_ready", 32'(data_ready), 32'd1);
        chk("reset_fs",    32'(frame_start), 32'd1);
        repeat (48) @(negedge serial_clock);
        chk("idle_no_rx",  32'(rx_words.size()), 32'd0);
        chk("idle_fs_E48", 32'(frame_start), 32'd1);

        // Single word offered at E0
        do_reset();
        base       = rx_words.size();
        data_in    = 15'h1234;
        data_valid = 1'b1;
        @(negedge serial_clock);
        data_valid = 1'b0;
        chk("t2_ready_low", 32'(data_ready), 32'd0);
        wait_rx(base + 1, 64);
        if (rx_words.size() > base) begin
            chk("t2_word", 32'(rx_words[base]), 32'h1234);
            chk("t2_edge", 32'(rx_edges[base]), 32'd31);
        end

        // Valid held high, incrementing words
        base = rx_words.size();
        send(15'h0001);
        send(15'h0002);
        send(15'h0003);
        wait_rx(base + 3, 96);
        if (rx_words.size() >= base + 3) begin
            chk("t3_w1", 32'(rx_words[base]),     32'h1);
            chk("t3_w2", 32'(rx_words[base + 1]), 32'h2);
            chk("t3_w3", 32'(rx_words[base + 2]), 32'h3);
            chk("t3_gap", 32'(rx_edges[base + 2] - rx_edges[base]), 32'd32);
        end

        // All ones then all zeros back to back
        base = rx_words.size();
        send(15'h7FFF);
        send(15'h0000);
        wait_rx(base + 2, 96);
        if (rx_words.size() >= base + 2) begin
            chk("t4_ones",  32'(rx_words[base]),     32'h7FFF);
            chk("t4_zeros", 32'(rx_words[base + 1]), 32'h0);
            chk("t4_gap",   32'(rx_edges[base + 1] - rx_edges[base]), 32'd16);
        end

        // Reset mid-frame with hold full
        do_reset();
        base = rx_words.size();
        send(15'h0AAA);
        send(15'h0BBB);
        n = 0;
        while (k != 20 && n < 64) begin
            @(negedge serial_clock);
            n++;
        end
        chk("t5_reach_E20", 32'(k), 32'd20);
        chk("t5_hold_full", 32'(data_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_serial", 32'(serial_data), 32'd0);
        chk("t5_rst_ready",  32'(data_ready),  32'd1);
        chk("t5_rst_busy",   32'(busy),        32'd0);
        chk("t5_rst_fs",     32'(frame_start), 32'd1);
        repeat (2) @(negedge serial_clock);
        #1 reset = 1'b0;
        repeat (48) @(negedge serial_clock);
        chk("t5_no_old_words", 32'(rx_words.size()), 32'(base));

        // Word offered exactly on a boundary edge
        do_reset();
        base = rx_words.size();
        n = 0;
        while (k != 15 && n < 32) begin
            @(negedge serial_clock);
            n++;
        end
        data_in    = 15'h5555;
        data_valid = 1'b1;
        @(negedge serial_clock);
        data_valid = 1'b0;
        chk("t6_accepted", 32'(data_ready), 32'd0);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        wait_rx(base + 1, 64);
        if (rx_words.size() > base) begin
            chk("t6_word", 32'(rx_words[base]), 32'h5555);
            chk("t6_edge", 32'(rx_edges[base]), 32'd47);
        end

        // Random traffic with one reset in the middle
        do_reset();
        base = rx_words.size();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            data_valid = ($urandom_range(0, 3) != 0);
            data_in    = DW'($urandom);
            @(negedge serial_clock);
        end
        data_valid = 1'b0;
        chk("rand_rx_seen", 32'(rx_words.size() > base), 32'd1);
        repeat (4) @(negedge serial_clock);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
